// File: rtl/expand_a_ctrl_pkg.sv
// Shared constants, types and FSM encodings for the ML-DSA ExpandA sequencer.
// ADDR_W is derived so that every {poly_idx, coef_idx} pair of the largest matrix fits.
package expand_a_ctrl_pkg;

    localparam int unsigned N      = 256;
    localparam int unsigned LOG_N  = $clog2(N);
    localparam int unsigned K_MAX  = 8;
    localparam int unsigned L_MAX  = 7;
    localparam int unsigned COEF_W = 24;
    localparam int unsigned POLY_W = $clog2(K_MAX * L_MAX);
    localparam int unsigned ADDR_W = POLY_W + LOG_N;
    localparam int unsigned DIM_W  = 4;
    localparam int unsigned RC_W   = 8;

    typedef enum logic [1:0] {
        LVL_44   = 2'd0,
        LVL_65   = 2'd1,
        LVL_87   = 2'd2,
        LVL_RSVD = 2'd3
    } level_e;

    typedef struct packed {
        logic [DIM_W-1:0] k;
        logic [DIM_W-1:0] l;
        logic             ok;
    } dims_t;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LOAD = 3'd1;
    localparam logic [2:0] ST_PROC = 3'd2;
    localparam logic [2:0] ST_WAIT = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    function automatic logic [ADDR_W-1:0] coef_addr(input logic [POLY_W-1:0] poly,
                                                    input logic [LOG_N-1:0]  coef);
        return {poly, coef};
    endfunction

endpackage

// File: rtl/expand_a_ctrl_if.sv
// Control, sampler handshake and A-matrix SRAM write port of the ExpandA sequencer.
// The controller uses the master modport; the surrounding environment uses slave.
interface expand_a_ctrl_if;
    import expand_a_ctrl_pkg::*;

    logic              start;
    logic              abort;
    level_e            level;
    logic              done_rej;
    logic              z_valid;
    logic [COEF_W-1:0] z_out;

    logic              start_rej;
    logic [RC_W-1:0]   row;
    logic [RC_W-1:0]   col;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W-1:0] mem_a;
    logic [COEF_W-1:0] mem_d;
    logic              mem_web;

    modport master (
        input  start, abort, level, done_rej, z_valid, z_out,
        output start_rej, row, col, busy, done, err, mem_a, mem_d, mem_web
    );

    modport slave (
        output start, abort, level, done_rej, z_valid, z_out,
        input  start_rej, row, col, busy, done, err, mem_a, mem_d, mem_web
    );

endinterface

// File: rtl/expand_a_ctrl_dims.sv
// Security level to matrix dimensions (K rows, L cols); purely combinational so the
// same decode can serve ExpandS/ExpandMask sequencers.
module expand_a_ctrl_dims
    import expand_a_ctrl_pkg::*;
(
    input  level_e i_level,
    output dims_t  o_dims
);

    always_comb begin
        o_dims = '0;
        unique case (i_level)
            LVL_44: begin
                o_dims.k  = DIM_W'(4);
                o_dims.l  = DIM_W'(4);
                o_dims.ok = 1'b1;
            end
            LVL_65: begin
                o_dims.k  = DIM_W'(6);
                o_dims.l  = DIM_W'(5);
                o_dims.ok = 1'b1;
            end
            LVL_87: begin
                o_dims.k  = DIM_W'(8);
                o_dims.l  = DIM_W'(7);
                o_dims.ok = 1'b1;
            end
            LVL_RSVD: o_dims.ok = 1'b0;
        endcase
    end

endmodule

// File: rtl/expand_a_ctrl.sv
// ExpandA sequencer: walks the K x L matrix, pulses the rejection sampler per polynomial
// and streams accepted coefficients into the A-matrix SRAM through a registered write port.
module expand_a_ctrl
    import expand_a_ctrl_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rst,
    expand_a_ctrl_if.master io_bus
);

    logic [2:0]        r_state;
    logic [RC_W-1:0]   r_row;
    logic [RC_W-1:0]   r_col;
    logic [POLY_W-1:0] r_poly;
    logic [LOG_N-1:0]  r_coef;
    logic [DIM_W-1:0]  r_k;
    logic [DIM_W-1:0]  r_l;
    logic              r_err;
    logic              r_done;
    logic              r_mem_web;
    logic [ADDR_W-1:0] r_mem_a;
    logic [COEF_W-1:0] r_mem_d;

    dims_t w_dims;
    logic  w_last_col;
    logic  w_last_row;
    logic  w_last_coef;
    logic  w_write;
    logic  w_advance;

    expand_a_ctrl_dims u_dims (
        .i_level (io_bus.level),
        .o_dims  (w_dims)
    );

    assign w_last_col  = (r_col == {{(RC_W - DIM_W){1'b0}}, r_l - DIM_W'(1)});
    assign w_last_row  = (r_row == {{(RC_W - DIM_W){1'b0}}, r_k - DIM_W'(1)});
    assign w_last_coef = (r_coef == LOG_N'(N - 1));
    assign w_write     = (r_state == ST_PROC) && io_bus.z_valid;
    // A final coefficient arriving together with done_rej skips the WAIT state.
    assign w_advance   = io_bus.done_rej &&
                         ((r_state == ST_WAIT) || (w_write && w_last_coef));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_row     <= '0;
            r_col     <= '0;
            r_poly    <= '0;
            r_coef    <= '0;
            r_k       <= '0;
            r_l       <= '0;
            r_err     <= 1'b0;
            r_done    <= 1'b0;
            r_mem_web <= 1'b1;
            r_mem_a   <= '0;
            r_mem_d   <= '0;
        end else begin
            r_done    <= 1'b0;
            r_mem_web <= 1'b1;
            if (io_bus.abort) begin
                r_state <= ST_IDLE;
            end else begin
                if (w_write) begin
                    r_mem_a   <= coef_addr(r_poly, r_coef);
                    r_mem_d   <= io_bus.z_out;
                    r_mem_web <= 1'b0;
                    r_coef    <= r_coef + 1'b1;
                end
                if (w_advance) begin
                    r_coef <= '0;
                    // The last (row,col) is left in place so it stays visible after the run.
                    if (w_last_row && w_last_col) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_poly  <= r_poly + 1'b1;
                        r_state <= ST_LOAD;
                        if (w_last_col) begin
                            r_col <= '0;
                            r_row <= r_row + 1'b1;
                        end else begin
                            r_col <= r_col + 1'b1;
                        end
                    end
                end else begin
                    case (r_state)
                        ST_IDLE: begin
                            if (io_bus.start) begin
                                if (w_dims.ok) begin
                                    r_state <= ST_LOAD;
                                    r_err   <= 1'b0;
                                    r_row   <= '0;
                                    r_col   <= '0;
                                    r_poly  <= '0;
                                    r_coef  <= '0;
                                    r_k     <= w_dims.k;
                                    r_l     <= w_dims.l;
                                end else begin
                                    r_err  <= 1'b1;
                                    r_done <= 1'b1;
                                end
                            end
                        end
                        ST_LOAD: r_state <= ST_PROC;
                        ST_PROC: begin
                            if (w_write && w_last_coef) begin
                                r_state <= ST_WAIT;
                            end else if (io_bus.done_rej) begin
                                r_err   <= 1'b1;
                                r_state <= ST_DONE;
                            end
                        end
                        ST_WAIT: ;
                        ST_DONE: begin
                            r_done  <= 1'b1;
                            r_state <= ST_IDLE;
                        end
                        default: r_state <= ST_IDLE;
                    endcase
                end
            end
        end
    end

    assign io_bus.start_rej = (r_state == ST_LOAD);
    assign io_bus.row       = r_row;
    assign io_bus.col       = r_col;
    assign io_bus.busy      = (r_state != ST_IDLE);
    assign io_bus.done      = r_done;
    assign io_bus.err       = r_err;
    assign io_bus.mem_a     = r_mem_a;
    assign io_bus.mem_d     = r_mem_d;
    assign io_bus.mem_web   = r_mem_web;

endmodule
